execute_stage: RTL and testbench

- EX stage of the 5-stage RV32I pipeline.
- Takes decoded operands from ID, resolves MEM/WB forwarding, and selects the ALU operands.
- Drives the existing alu block, resolves branches and jumps, and registers the results into the EX/MEM pipeline register consumed by the memory stage.

---
 rtl/rv32i_pkg.sv | 48 ++++
 rtl/alu.sv | 32 +++
 rtl/branch_cmp.sv | 26 ++
 rtl/execute_stage.sv | 143 ++++++++++++++
 tb/tb_execute_stage.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the execute stage: datapath width, ALU
// operation codes, branch condition codes and the EX/MEM register layout.
package rv32i_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_PASS = 4'b1001;
    localparam logic [3:0] ALU_JALR = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    // Everything the memory stage consumes from EX, held as one register.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] store_data;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
    } ex_mem_t;

    // A bubble carries no side effects; only the valid bit is selectable
    // so the reset/flush value can follow the stage parameter.
    function automatic ex_mem_t ex_bubble(input logic valid_val);
        ex_mem_t b;
        b       = '0;
        b.valid = valid_val;
        return b;
    endfunction

endpackage

// File: rtl/alu.sv
// RV32I integer ALU. Purely combinational; unknown op codes give zero so a
// mis-decoded instruction cannot leak stale operand values downstream.
module alu
    import rv32i_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      op,
    output logic [XLEN-1:0] y
);

    // Operation select; shifts only honour the low five bits of b.
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SLL:  y = a << b[4:0];
            ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:  y = a ^ b;
            ALU_SRL:  y = a >> b[4:0];
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            ALU_SUB:  y = a - b;
            ALU_PASS: y = b;
            ALU_JALR: y = (a + b) & {{(XLEN-1){1'b1}}, 1'b0};
            ALU_SRA:  y = $signed(a) >>> b[4:0];
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/branch_cmp.sv
// Branch condition evaluator. Works on the forwarded register values and is
// independent of the ALU so the ALU can compute the target at the same time.
module branch_cmp
    import rv32i_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      funct3,
    output logic            taken
);

    // Condition decode; the two reserved encodings never branch.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            BR_EQ:   taken = (a == b);
            BR_NE:   taken = (a != b);
            BR_LT:   taken = ($signed(a) <  $signed(b));
            BR_GE:   taken = ($signed(a) >= $signed(b));
            BR_LTU:  taken = (a <  b);
            BR_GEU:  taken = (a >= b);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// EX stage of the 5-stage RV32I pipeline: operand forwarding, ALU operand
// selection, branch/jump resolution and the EX/MEM pipeline register.
module execute_stage #(
    parameter int   XLEN            = rv32i_pkg::XLEN,
    parameter logic RESET_PC_BUBBLE = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rd,
    input  logic [3:0]      id_alu_op,
    input  logic            id_src1_pc,
    input  logic            id_src2_imm,
    input  logic            id_is_branch,
    input  logic            id_is_jump,
    input  logic [2:0]      id_funct3,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_reg_write,
    input  logic            mem_fwd_we,
    input  logic [4:0]      mem_fwd_rd,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic            wb_fwd_we,
    input  logic [4:0]      wb_fwd_rd,
    input  logic [XLEN-1:0] wb_fwd_data,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_result,
    output logic [XLEN-1:0] ex_store_data,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write
);

    import rv32i_pkg::*;

    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic [XLEN-1:0] alu_in1;
    logic [XLEN-1:0] alu_in2;
    logic [XLEN-1:0] alu_y;
    logic            br_taken;
    ex_mem_t         ex_mem_d;
    ex_mem_t         ex_mem_q;

    // Forwarding for rs1: the younger MEM result beats WB, and x0 always
    // takes the register file value, which is hard-wired to zero.
    always_comb begin
        fwd_rs1 = id_rs1_data;
        if (mem_fwd_we && (mem_fwd_rd == id_rs1) && (id_rs1 != 5'd0)) begin
            fwd_rs1 = mem_fwd_data;
        end else if (wb_fwd_we && (wb_fwd_rd == id_rs1) && (id_rs1 != 5'd0)) begin
            fwd_rs1 = wb_fwd_data;
        end
    end

    // Forwarding for rs2, same priority rules as rs1.
    always_comb begin
        fwd_rs2 = id_rs2_data;
        if (mem_fwd_we && (mem_fwd_rd == id_rs2) && (id_rs2 != 5'd0)) begin
            fwd_rs2 = mem_fwd_data;
        end else if (wb_fwd_we && (wb_fwd_rd == id_rs2) && (id_rs2 != 5'd0)) begin
            fwd_rs2 = wb_fwd_data;
        end
    end

    // ALU operand selection: PC-relative forms use the PC, immediates replace rs2.
    always_comb begin
        alu_in1 = id_src1_pc  ? id_pc  : fwd_rs1;
        alu_in2 = id_src2_imm ? id_imm : fwd_rs2;
    end

    alu u_alu (
        .a  (alu_in1),
        .b  (alu_in2),
        .op (id_alu_op),
        .y  (alu_y)
    );

    branch_cmp u_branch_cmp (
        .a      (fwd_rs1),
        .b      (fwd_rs2),
        .funct3 (id_funct3),
        .taken  (br_taken)
    );

    // Redirect leaves the stage in the same cycle; a stalled or resetting
    // slot must never steer fetch, since it will be replayed or discarded.
    always_comb begin
        redirect    = id_valid && !stall && !rst &&
                      (id_is_jump || (id_is_branch && br_taken));
        redirect_pc = alu_y;
    end

    // Next EX/MEM contents; side-effecting controls only survive for a real
    // instruction, so an empty ID/EX slot becomes a bubble.
    always_comb begin
        ex_mem_d            = '0;
        ex_mem_d.valid      = id_valid;
        ex_mem_d.result     = id_is_jump ? (id_pc + 32'd4) : alu_y;
        ex_mem_d.store_data = fwd_rs2;
        ex_mem_d.rd         = id_rd;
        ex_mem_d.funct3     = id_funct3;
        ex_mem_d.mem_read   = id_valid && id_mem_read;
        ex_mem_d.mem_write  = id_valid && id_mem_write;
        ex_mem_d.reg_write  = id_valid && id_reg_write;
    end

    // EX/MEM register: reset beats flush, flush beats stall, stall holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_mem_q <= ex_bubble(RESET_PC_BUBBLE);
        end else if (flush) begin
            ex_mem_q <= ex_bubble(RESET_PC_BUBBLE);
        end else if (!stall) begin
            ex_mem_q <= ex_mem_d;
        end
    end

    // Unpack the register onto the memory-stage interface.
    always_comb begin
        ex_valid      = ex_mem_q.valid;
        ex_result     = ex_mem_q.result;
        ex_store_data = ex_mem_q.store_data;
        ex_rd         = ex_mem_q.rd;
        ex_funct3     = ex_mem_q.funct3;
        ex_mem_read   = ex_mem_q.mem_read;
        ex_mem_write  = ex_mem_q.mem_write;
        ex_reg_write  = ex_mem_q.reg_write;
    end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: a table of instruction vectors with
// hand-computed results feeds a scoreboard queue, followed by hand-written
// stall, flush and reset sequences.
module tb_execute_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic [4:0]  id_rd;
    logic [3:0]  id_alu_op;
    logic        id_src1_pc;
    logic        id_src2_imm;
    logic        id_is_branch;
    logic        id_is_jump;
    logic [2:0]  id_funct3;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        id_reg_write;
    logic        mem_fwd_we;
    logic [4:0]  mem_fwd_rd;
    logic [31:0] mem_fwd_data;
    logic        wb_fwd_we;
    logic [4:0]  wb_fwd_rd;
    logic [31:0] wb_fwd_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ex_valid;
    logic [31:0] ex_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_reg_write;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  op;
        logic        src1_pc;
        logic        src2_imm;
        logic        is_branch;
        logic        is_jump;
        logic [2:0]  funct3;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        mem_we;
        logic [4:0]  mem_rd;
        logic [31:0] mem_data;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        exp_redirect;
        logic [31:0] exp_redirect_pc;
        logic [31:0] exp_result;
        logic [31:0] exp_store;
    } vec_t;

    typedef struct {
        string       tag;
        logic        valid;
        logic [31:0] result;
        logic [31:0] store;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [2:0]  ctrl;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    execute_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rs1_data   (id_rs1_data),
        .id_rs2_data   (id_rs2_data),
        .id_imm        (id_imm),
        .id_rd         (id_rd),
        .id_alu_op     (id_alu_op),
        .id_src1_pc    (id_src1_pc),
        .id_src2_imm   (id_src2_imm),
        .id_is_branch  (id_is_branch),
        .id_is_jump    (id_is_jump),
        .id_funct3     (id_funct3),
        .id_mem_read   (id_mem_read),
        .id_mem_write  (id_mem_write),
        .id_reg_write  (id_reg_write),
        .mem_fwd_we    (mem_fwd_we),
        .mem_fwd_rd    (mem_fwd_rd),
        .mem_fwd_data  (mem_fwd_data),
        .wb_fwd_we     (wb_fwd_we),
        .wb_fwd_rd     (wb_fwd_rd),
        .wb_fwd_data   (wb_fwd_data),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .ex_valid      (ex_valid),
        .ex_result     (ex_result),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .ex_funct3     (ex_funct3),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_reg_write  (ex_reg_write)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    function automatic vec_t blank_vec();
        vec_t v;
        v = '{default: '0};
        v.valid = 1'b1;
        v.rs1   = 5'd1;
        v.rs2   = 5'd2;
        v.rd    = 5'd3;
        return v;
    endfunction

    function automatic vec_t alu_row(input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input logic [31:0] y);
        vec_t v;
        v = blank_vec();
        v.op              = op;
        v.rs1_data        = a;
        v.rs2_data        = b;
        v.reg_write       = 1'b1;
        v.funct3          = 3'b001;
        v.exp_redirect_pc = y;
        v.exp_result      = y;
        v.exp_store       = b;
        return v;
    endfunction

    function automatic vec_t branch_row(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b, input logic tk);
        vec_t v;
        v = blank_vec();
        v.pc              = 32'h100;
        v.imm             = 32'h20;
        v.src1_pc         = 1'b1;
        v.src2_imm        = 1'b1;
        v.is_branch       = 1'b1;
        v.funct3          = f3;
        v.rs1_data        = a;
        v.rs2_data        = b;
        v.exp_redirect    = tk;
        v.exp_redirect_pc = 32'h120;
        v.exp_result      = 32'h120;
        v.exp_store       = b;
        return v;
    endfunction

    // Drive one vector onto the ID/EX inputs and queue what EX/MEM must hold after the edge
    task automatic applyStimulus(input vec_t v, input string tag);
        exp_t e;
        id_valid     = v.valid;
        id_pc        = v.pc;
        id_rs1       = v.rs1;
        id_rs2       = v.rs2;
        id_rs1_data  = v.rs1_data;
        id_rs2_data  = v.rs2_data;
        id_imm       = v.imm;
        id_rd        = v.rd;
        id_alu_op    = v.op;
        id_src1_pc   = v.src1_pc;
        id_src2_imm  = v.src2_imm;
        id_is_branch = v.is_branch;
        id_is_jump   = v.is_jump;
        id_funct3    = v.funct3;
        id_mem_read  = v.mem_read;
        id_mem_write = v.mem_write;
        id_reg_write = v.reg_write;
        mem_fwd_we   = v.mem_we;
        mem_fwd_rd   = v.mem_rd;
        mem_fwd_data = v.mem_data;
        wb_fwd_we    = v.wb_we;
        wb_fwd_rd    = v.wb_rd;
        wb_fwd_data  = v.wb_data;
        if (!stall && !flush && !rst) begin
            e.tag    = tag;
            e.valid  = v.valid;
            e.result = v.exp_result;
            e.store  = v.exp_store;
            e.rd     = v.rd;
            e.funct3 = v.funct3;
            e.ctrl   = v.valid ? {v.mem_read, v.mem_write, v.reg_write} : 3'b000;
            sb.push_back(e);
        end
    endtask

    // Pop the oldest expectation and compare it with the EX/MEM register
    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_empty actual=0 required=1");
        end else begin
            e = sb.pop_front();
            check_val({e.tag, " ex_valid"},      {31'd0, ex_valid}, {31'd0, e.valid});
            check_val({e.tag, " ex_result"},     ex_result, e.result);
            check_val({e.tag, " ex_store_data"}, ex_store_data, e.store);
            check_val({e.tag, " ex_rd"},         {27'd0, ex_rd}, {27'd0, e.rd});
            check_val({e.tag, " ex_funct3"},     {29'd0, ex_funct3}, {29'd0, e.funct3});
            check_val({e.tag, " ex_ctrl"},
                      {29'd0, ex_mem_read, ex_mem_write, ex_reg_write}, {29'd0, e.ctrl});
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, " ex_valid"},      {31'd0, ex_valid}, 32'd0);
        check_val({tag, " ex_result"},     ex_result, 32'd0);
        check_val({tag, " ex_store_data"}, ex_store_data, 32'd0);
        check_val({tag, " ex_rd"},         {27'd0, ex_rd}, 32'd0);
        check_val({tag, " ex_funct3"},     {29'd0, ex_funct3}, 32'd0);
        check_val({tag, " ex_ctrl"},
                  {29'd0, ex_mem_read, ex_mem_write, ex_reg_write}, 32'd0);
    endtask

    initial begin
        vec_t v;
        vec_t jv;
        vec_t tk;

        rst   = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        v = blank_vec();
        v.is_jump = 1'b1;
        applyStimulus(v, "reset");
        @(negedge clk);
        @(negedge clk);
        #1;
        check_val("reset redirect", {31'd0, redirect}, 32'd0);
        check_all_zero("reset");
        rst = 1'b0;

        // ALU coverage
        vecs.push_back(alu_row(4'b0000, 32'd5,        32'd7,        32'd12));
        vecs.push_back(alu_row(4'b0000, 32'hFFFFFFFF, 32'd2,        32'd1));
        vecs.push_back(alu_row(4'b0001, 32'd1,        32'h23,       32'd8));
        vecs.push_back(alu_row(4'b0010, 32'hFFFFFFFF, 32'd1,        32'd1));
        vecs.push_back(alu_row(4'b0011, 32'hFFFFFFFF, 32'd1,        32'd0));
        vecs.push_back(alu_row(4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0));
        vecs.push_back(alu_row(4'b0101, 32'h80000000, 32'd4,        32'h08000000));
        vecs.push_back(alu_row(4'b0110, 32'hF0F0F0F0, 32'h0F000000, 32'hFFF0F0F0));
        vecs.push_back(alu_row(4'b0111, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000));
        vecs.push_back(alu_row(4'b1000, 32'd5,        32'd7,        32'hFFFFFFFE));
        vecs.push_back(alu_row(4'b1001, 32'h1234,     32'hABCDE000, 32'hABCDE000));
        vecs.push_back(alu_row(4'b1010, 32'h1003,     32'd4,        32'h1006));
        vecs.push_back(alu_row(4'b1101, 32'h80000000, 32'h21,       32'hC0000000));
        vecs.push_back(alu_row(4'b1011, 32'h1234,     32'h5678,     32'd0));
        vecs.push_back(alu_row(4'b1111, 32'h1234,     32'h5678,     32'd0));

        // MEM forwarding wins over WB on rs1
        v = blank_vec();
        v.rs1 = 5'd5; v.rs1_data = 32'd1; v.rs2 = 5'd6; v.rs2_data = 32'h55;
        v.mem_we = 1'b1; v.mem_rd = 5'd5; v.mem_data = 32'd100;
        v.wb_we  = 1'b1; v.wb_rd  = 5'd5; v.wb_data  = 32'd7;
        v.imm = 32'd3; v.src2_imm = 1'b1; v.reg_write = 1'b1;
        v.exp_redirect_pc = 32'd103; v.exp_result = 32'd103; v.exp_store = 32'h55;
        vecs.push_back(v);

        // WB forwarding on rs2 when MEM targets another register
        v = blank_vec();
        v.rs1 = 5'd3; v.rs1_data = 32'd1; v.rs2 = 5'd9; v.rs2_data = 32'd0;
        v.mem_we = 1'b1; v.mem_rd = 5'd8; v.mem_data = 32'h999;
        v.wb_we  = 1'b1; v.wb_rd  = 5'd9; v.wb_data  = 32'h77;
        v.reg_write = 1'b1;
        v.exp_redirect_pc = 32'h78; v.exp_result = 32'h78; v.exp_store = 32'h77;
        vecs.push_back(v);

        // x0 is never forwarded
        v = blank_vec();
        v.rs1 = 5'd0; v.rs1_data = 32'd0; v.rs2 = 5'd0; v.rs2_data = 32'd0;
        v.mem_we = 1'b1; v.mem_rd = 5'd0; v.mem_data = 32'hDEADBEEF;
        v.wb_we  = 1'b1; v.wb_rd  = 5'd0; v.wb_data  = 32'h12345678;
        v.src2_imm = 1'b1; v.reg_write = 1'b1;
        vecs.push_back(v);

        // Branch conditions
        vecs.push_back(branch_row(3'b100, 32'hFFFFFFFF, 32'd1, 1'b1));
        vecs.push_back(branch_row(3'b110, 32'hFFFFFFFF, 32'd1, 1'b0));
        vecs.push_back(branch_row(3'b101, 32'hFFFFFFFF, 32'd1, 1'b0));
        vecs.push_back(branch_row(3'b111, 32'hFFFFFFFF, 32'd1, 1'b1));
        vecs.push_back(branch_row(3'b000, 32'd5, 32'd5, 1'b1));
        vecs.push_back(branch_row(3'b001, 32'd5, 32'd5, 1'b0));
        vecs.push_back(branch_row(3'b001, 32'd5, 32'd6, 1'b1));
        vecs.push_back(branch_row(3'b010, 32'd5, 32'd5, 1'b0));
        vecs.push_back(branch_row(3'b011, 32'd5, 32'd5, 1'b0));

        // Branch compare sees forwarded operands
        v = branch_row(3'b000, 32'd0, 32'd9, 1'b1);
        v.mem_we = 1'b1; v.mem_rd = 5'd1; v.mem_data = 32'd9;
        vecs.push_back(v);
        v = branch_row(3'b000, 32'd9, 32'd0, 1'b1);
        v.wb_we = 1'b1; v.wb_rd = 5'd2; v.wb_data = 32'd9; v.exp_store = 32'd9;
        vecs.push_back(v);

        // Invalid slot: no redirect, bubble with all controls low
        v = branch_row(3'b000, 32'd5, 32'd5, 1'b0);
        v.valid = 1'b0; v.mem_write = 1'b1; v.reg_write = 1'b1; v.mem_read = 1'b1;
        vecs.push_back(v);

        // JALR
        v = blank_vec();
        v.pc = 32'h40; v.rs1_data = 32'h1003; v.imm = 32'd4; v.src2_imm = 1'b1;
        v.op = 4'b1010; v.is_jump = 1'b1; v.rd = 5'd1; v.reg_write = 1'b1;
        v.exp_redirect = 1'b1; v.exp_redirect_pc = 32'h1006; v.exp_result = 32'h44;
        vecs.push_back(v);

        // JAL with PC+4 and target both wrapping
        v = blank_vec();
        v.pc = 32'hFFFFFFFC; v.imm = 32'd8; v.src1_pc = 1'b1; v.src2_imm = 1'b1;
        v.is_jump = 1'b1; v.rd = 5'd1; v.reg_write = 1'b1;
        v.exp_redirect = 1'b1; v.exp_redirect_pc = 32'h4; v.exp_result = 32'h0;
        vecs.push_back(v);

        // Load and store address generation with control pass-through
        v = blank_vec();
        v.rs1_data = 32'h1000; v.imm = 32'd8; v.src2_imm = 1'b1; v.funct3 = 3'b010;
        v.mem_read = 1'b1; v.reg_write = 1'b1; v.rd = 5'd10;
        v.exp_redirect_pc = 32'h1008; v.exp_result = 32'h1008;
        vecs.push_back(v);
        v = blank_vec();
        v.rs1_data = 32'h2000; v.imm = 32'hFFFFFFFC; v.src2_imm = 1'b1; v.funct3 = 3'b010;
        v.rs2_data = 32'hCAFEBABE; v.mem_write = 1'b1; v.rd = 5'd0;
        v.exp_redirect_pc = 32'h1FFC; v.exp_result = 32'h1FFC; v.exp_store = 32'hCAFEBABE;
        vecs.push_back(v);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i], $sformatf("v%0d", i));
            #1;
            check_val($sformatf("v%0d redirect", i), {31'd0, redirect}, {31'd0, vecs[i].exp_redirect});
            check_val($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].exp_redirect_pc);
            @(negedge clk);
            checkOutput();
        end

        // Stall: hold for two cycles while inputs change, no redirect
        jv = blank_vec();
        jv.pc = 32'h200; jv.imm = 32'h10; jv.src1_pc = 1'b1; jv.src2_imm = 1'b1;
        jv.is_jump = 1'b1; jv.rd = 5'd5; jv.reg_write = 1'b1;
        jv.exp_redirect = 1'b1; jv.exp_redirect_pc = 32'h210; jv.exp_result = 32'h204;
        applyStimulus(jv, "pre_stall");
        @(negedge clk);
        checkOutput();
        stall = 1'b1;
        for (int c = 0; c < 2; c++) begin
            v = blank_vec();
            v.pc = 32'h300 + 32'(c * 4); v.imm = 32'h40; v.src1_pc = 1'b1; v.src2_imm = 1'b1;
            v.is_jump = 1'b1; v.rd = 5'd7; v.reg_write = 1'b1; v.mem_write = 1'b1;
            applyStimulus(v, "stalled");
            #1;
            check_val($sformatf("stall%0d redirect", c), {31'd0, redirect}, 32'd0);
            @(negedge clk);
            check_val($sformatf("stall%0d ex_result", c), ex_result, 32'h204);
            check_val($sformatf("stall%0d ex_rd", c), {27'd0, ex_rd}, 32'd5);
            check_val($sformatf("stall%0d ex_ctrl", c),
                      {29'd0, ex_mem_read, ex_mem_write, ex_reg_write}, 32'b001);
        end
        stall = 1'b0;
        v.exp_redirect = 1'b1; v.exp_redirect_pc = 32'h344; v.exp_result = 32'h308;
        applyStimulus(v, "post_stall");
        #1;
        check_val("post_stall redirect_pc", redirect_pc, 32'h344);
        @(negedge clk);
        checkOutput();

        // Flush and stall together: flush wins
        stall = 1'b1;
        flush = 1'b1;
        applyStimulus(jv, "flush_stall");
        @(negedge clk);
        check_val("flush_stall ex_valid", {31'd0, ex_valid}, 32'd0);
        check_val("flush_stall ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
        check_val("flush_stall ex_result", ex_result, 32'd0);
        stall = 1'b0;
        flush = 1'b0;

        // Reset mid-stream while stalled with a taken branch on the inputs
        applyStimulus(jv, "pre_reset");
        @(negedge clk);
        checkOutput();
        tk = branch_row(3'b000, 32'd5, 32'd5, 1'b1);
        tk.reg_write = 1'b1;
        rst = 1'b1;
        applyStimulus(tk, "in_reset");
        #1;
        check_val("in_reset redirect", {31'd0, redirect}, 32'd0);
        @(negedge clk);
        check_all_zero("mid_reset");
        stall = 1'b1;
        @(negedge clk);
        check_all_zero("reset_stall");
        rst   = 1'b0;
        stall = 1'b0;
        applyStimulus(tk, "after_reset");
        #1;
        check_val("after_reset redirect", {31'd0, redirect}, 32'd1);
        @(negedge clk);
        checkOutput();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
